// File: rtl/i8080_system_controller.sv
// rtl/i8080_system_controller.sv - i8080 status latch, strobe decode, bus steering and READY wait states; optional RST 7 vector injection under I8080_RST7_INJECT_EN
module i8080_system_controller #(
  parameter int XLEN        = 8,
  parameter int WAIT_STATES = 0,
  parameter int WCNT_W      = 4
) (
  input  logic            clk,
  input  logic            rst,
  inout  wire  [XLEN-1:0] bus,
  input  logic            sync,
  input  logic            dbin,
  input  logic            wr_n,
  inout  wire  [XLEN-1:0] sys_data,
  output logic            memr,
  output logic            memw,
  output logic            ior,
  output logic            iow,
  output logic            inta,
  output logic            halt,
  output logic            ready,
  output logic [XLEN-1:0] status_q
);

  // Status byte bit positions as driven by the CPU during SYNC
  localparam int B_INTA  = 0;
  localparam int B_WO_N  = 1;
  localparam int B_HLTA  = 3;
  localparam int B_OUT   = 4;
  localparam int B_INP   = 6;
  localparam int B_MEMR  = 7;

  localparam logic [WCNT_W-1:0] WAIT_INIT  = WCNT_W'(WAIT_STATES);
  localparam logic              READY_INIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCHED,
    S_ACTIVE,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   status_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              ready_q, ready_d;
  logic              halt_q, halt_d;

  logic strobe_en;
  logic memr_s, memw_s, ior_s, iow_s, inta_s;
  logic rd_any, wr_any, any_strobe;

  logic            bus_drv_en;
  logic [XLEN-1:0] bus_drv_val;
  logic            sys_drv_en;

  // Strobe decode: only a latched or active cycle with READY high may assert a strobe
  always_comb begin
    strobe_en  = ((state_q == S_LATCHED) || (state_q == S_ACTIVE)) && ready_q;
    memr_s     = strobe_en & dbin & status_q[B_MEMR];
    ior_s      = strobe_en & dbin & status_q[B_INP];
    inta_s     = strobe_en & dbin & status_q[B_INTA];
    memw_s     = strobe_en & ~wr_n & ~status_q[B_WO_N] & ~status_q[B_OUT] & ~status_q[B_INP];
    iow_s      = strobe_en & ~wr_n & ~status_q[B_WO_N] & status_q[B_OUT];
    rd_any     = memr_s | ior_s | inta_s;
    wr_any     = memw_s | iow_s;
    any_strobe = rd_any | wr_any;
  end

  // Data steering: reads win over writes so the two buses never drive each other at once
  always_comb begin
    sys_drv_en = wr_any & ~rd_any;
    bus_drv_en = rd_any;
`ifdef I8080_RST7_INJECT_EN
    bus_drv_val = inta_s ? XLEN'(8'hFF) : sys_data;
`else
    bus_drv_val = sys_data;
`endif
  end

  assign bus      = bus_drv_en ? bus_drv_val : {XLEN{1'bz}};
  assign sys_data = sys_drv_en ? bus : {XLEN{1'bz}};

  assign memr  = memr_s;
  assign memw  = memw_s;
  assign ior   = ior_s;
  assign iow   = iow_s;
  assign inta  = inta_s;
  assign halt  = halt_q;
  assign ready = ready_q;

  // Next-state logic: SYNC always restarts a cycle, otherwise walk latch -> wait -> active -> idle
  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    wait_cnt_d = wait_cnt_q;
    ready_d    = ready_q;
    halt_d     = halt_q;
    if (sync) begin
      status_d   = bus;
      wait_cnt_d = WAIT_INIT;
      ready_d    = READY_INIT;
      halt_d     = 1'b0;
      state_d    = S_LATCHED;
    end else begin
      case (state_q)
        S_LATCHED: begin
          if (status_q[B_HLTA]) begin
            state_d    = S_HALT;
            halt_d     = 1'b1;
            ready_d    = 1'b1;
            wait_cnt_d = '0;
          end else if (wait_cnt_q != '0) begin
            wait_cnt_d = wait_cnt_q - WCNT_W'(1);
            ready_d    = (wait_cnt_q == WCNT_W'(1));
          end else if (any_strobe) begin
            state_d = S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (!any_strobe) begin
            state_d = S_IDLE;
          end
        end
        S_HALT: begin
          halt_d  = 1'b1;
          ready_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      status_q   <= '0;
      wait_cnt_q <= '0;
      ready_q    <= 1'b1;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      wait_cnt_q <= wait_cnt_d;
      ready_q    <= ready_d;
      halt_q     <= halt_d;
    end
  end

endmodule

// File: tb/tb_i8080_system_controller.sv
// tb/tb_i8080_system_controller.sv - self-checking bench for i8080_system_controller (WAIT_STATES 0 and 2 side by side)
module tb_i8080_system_controller;

`ifdef I8080_RST7_INJECT_EN
  localparam bit RST7 = 1'b1;
`else
  localparam bit RST7 = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, sync = 1'b0, dbin = 1'b0, wr_n = 1'b1;
  logic [7:0] bv = 8'h00, sv = 8'h00;
  logic       bus_en = 1'b0, sys_en = 1'b0;

  wire [7:0] bus0, sys0, bus2, sys2;
  assign bus0 = bus_en ? bv : 8'hzz;
  assign bus2 = bus_en ? bv : 8'hzz;
  assign sys0 = sys_en ? sv : 8'hzz;
  assign sys2 = sys_en ? sv : 8'hzz;

  logic [1:0] memr_o, memw_o, ior_o, iow_o, inta_o, halt_o, ready_o;
  logic [7:0] st_o [2];

  i8080_system_controller #(.XLEN(8), .WAIT_STATES(0), .WCNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .sync(sync), .dbin(dbin), .wr_n(wr_n),
    .sys_data(sys0), .memr(memr_o[0]), .memw(memw_o[0]), .ior(ior_o[0]),
    .iow(iow_o[0]), .inta(inta_o[0]), .halt(halt_o[0]), .ready(ready_o[0]),
    .status_q(st_o[0])
  );

  i8080_system_controller #(.XLEN(8), .WAIT_STATES(2), .WCNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .sync(sync), .dbin(dbin), .wr_n(wr_n),
    .sys_data(sys2), .memr(memr_o[1]), .memw(memw_o[1]), .ior(ior_o[1]),
    .iow(iow_o[1]), .inta(inta_o[1]), .halt(halt_o[1]), .ready(ready_o[1]),
    .status_q(st_o[1])
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic chk_ne(input string name, input logic [7:0] act, input logic [7:0] forbidden);
    total++;
    if (act !== forbidden) passed++;
    else $display("FAIL %s actual=%h required=undriven (not %h)", name, act, forbidden);
  endtask

  // Reference model: edges elapsed since the last SYNC decide READY/HALT; a cycle closes
  // after strobes have been seen and then drop.
  int         ws_m [2] = '{0, 2};
  int         n_m  [2];
  bit         lat_m[2], seen_m[2], done_m[2];
  logic [7:0] st_m [2];
  bit         model_valid = 1'b0;

  function automatic logic [4:0] decode(input logic [7:0] s, input logic d, input logic w);
    logic [4:0] r;
    r[4] = d & s[7];
    r[3] = ~w & ~s[1] & ~s[4] & ~s[6];
    r[2] = d & s[6];
    r[1] = ~w & ~s[1] & s[4];
    r[0] = d & s[0];
    return r;
  endfunction

  function automatic bit halted(input int i);
    return lat_m[i] && st_m[i][3] && (n_m[i] >= 1);
  endfunction

  function automatic bit window(input int i);
    return lat_m[i] && !done_m[i] && !halted(i) && (n_m[i] >= ws_m[i]);
  endfunction

  function automatic logic [4:0] exp_strobes(input int i);
    return window(i) ? decode(st_m[i], dbin, wr_n) : 5'b0;
  endfunction

  function automatic bit exp_ready(input int i);
    return !lat_m[i] || halted(i) || (n_m[i] >= ws_m[i]);
  endfunction

  task automatic model_edge(input int i);
    logic [4:0] s;
    bit         w;
    if (rst) begin
      lat_m[i] = 0; st_m[i] = 8'h00; n_m[i] = 0; seen_m[i] = 0; done_m[i] = 0;
    end else if (sync) begin
      lat_m[i] = 1; st_m[i] = bv; n_m[i] = 0; seen_m[i] = 0; done_m[i] = 0;
    end else begin
      w = window(i);
      s = exp_strobes(i);
      if (w) begin
        if (seen_m[i] && s == 5'b0) done_m[i] = 1;
        else if (s != 5'b0) seen_m[i] = 1;
      end
      if (lat_m[i] && n_m[i] < 1000) n_m[i]++;
    end
  endtask

  task automatic drive(input bit r_i, input bit sy_i, input bit d_i, input bit w_i,
                       input logic [7:0] b_i, input logic [7:0] s_i);
    @(negedge clk);
    rst = r_i; sync = sy_i; dbin = d_i; wr_n = w_i; bv = b_i; sv = s_i;
    bus_en = sy_i | ~w_i;
    sys_en = d_i;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    if (rst) model_valid = 1'b1;
  endtask

  task automatic data_chk(input int i, input logic [4:0] es, input string tag);
    logic [7:0] b_act, s_act;
    bit rd, wr;
    b_act = (i == 0) ? bus0 : bus2;
    s_act = (i == 0) ? sys0 : sys2;
    rd = es[4] | es[2] | es[0];
    wr = (es[3] | es[1]) && !rd;
    if (rd) chk({tag, "_bus_rd"}, 32'(b_act), 32'((RST7 && es[0]) ? 8'hFF : sv));
    else if (sys_en && !bus_en && sv != 8'h00) chk_ne({tag, "_bus_z"}, b_act, sv);
    if (wr) chk({tag, "_sys_wr"}, 32'(s_act), 32'(bv));
    else if (bus_en && !sys_en && bv != 8'h00) chk_ne({tag, "_sys_z"}, s_act, bv);
  endtask

  task automatic check_model();
    logic [4:0] es;
    if (!model_valid) return;
    for (int i = 0; i < 2; i++) begin
      es = exp_strobes(i);
      chk($sformatf("model_u%0d", i),
          32'({memr_o[i], memw_o[i], ior_o[i], iow_o[i], inta_o[i], halt_o[i], ready_o[i], st_o[i]}),
          32'({es, halted(i) && !done_m[i], exp_ready(i), st_m[i]}));
      data_chk(i, es, $sformatf("model_u%0d", i));
    end
  endtask

  typedef struct {
    bit         chk;
    bit         r, sy, d, w;
    logic [7:0] b, s;
    logic [4:0] stb;
    bit         h, rdy;
    logic [7:0] st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit c, input bit r, input bit sy, input bit d, input bit w,
                     input logic [7:0] b, input logic [7:0] s, input logic [4:0] stb,
                     input bit h, input bit rdy, input logic [7:0] st);
    vec_t v;
    v.chk = c; v.r = r; v.sy = sy; v.d = d; v.w = w; v.b = b; v.s = s;
    v.stb = stb; v.h = h; v.rdy = rdy; v.st = st;
    tbl.push_back(v);
  endtask

  function automatic logic [7:0] pick_status();
    logic [7:0] lst [8];
    lst = '{8'hA2, 8'h82, 8'h00, 8'h10, 8'h42, 8'h8A, 8'h23, 8'h86};
    if ($urandom_range(0, 1) == 0) return lst[$urandom_range(0, 7)];
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    // strobes field = {memr, memw, ior, iow, inta}; expectations are for the WAIT_STATES=0 unit
    //  chk r sy d w  bus    sys    strobes   h rdy status
    add(0, 1, 0, 0, 1, 8'h00, 8'h00, 5'b00000, 0, 1, 8'h00);
    add(1, 0, 0, 0, 1, 8'h00, 8'h00, 5'b00000, 0, 1, 8'h00); // reset state
    add(1, 0, 1, 1, 1, 8'hA2, 8'h3C, 5'b00000, 0, 1, 8'h00); // sync + dbin same cycle
    add(1, 0, 0, 1, 1, 8'h00, 8'h3C, 5'b10000, 0, 1, 8'hA2); // memory read
    add(1, 0, 0, 1, 1, 8'h00, 8'h3C, 5'b10000, 0, 1, 8'hA2);
    add(1, 0, 0, 0, 1, 8'h00, 8'h3C, 5'b00000, 0, 1, 8'hA2); // dbin falls
    add(1, 0, 0, 1, 1, 8'h00, 8'h3C, 5'b00000, 0, 1, 8'hA2); // idle again
    add(1, 0, 1, 0, 1, 8'h00, 8'h00, 5'b00000, 0, 1, 8'hA2);
    add(1, 0, 0, 0, 0, 8'h55, 8'h00, 5'b01000, 0, 1, 8'h00); // memory write
    add(1, 0, 0, 0, 1, 8'h55, 8'h00, 5'b00000, 0, 1, 8'h00);
    add(1, 0, 1, 0, 1, 8'h10, 8'h00, 5'b00000, 0, 1, 8'h00);
    add(1, 0, 0, 0, 0, 8'h77, 8'h00, 5'b00010, 0, 1, 8'h10); // I/O write
    add(1, 0, 0, 0, 1, 8'h00, 8'h00, 5'b00000, 0, 1, 8'h10);
    add(1, 0, 1, 0, 1, 8'h8A, 8'h00, 5'b00000, 0, 1, 8'h10); // halt status
    add(1, 0, 0, 0, 1, 8'h00, 8'h00, 5'b00000, 0, 1, 8'h8A);
    add(1, 0, 0, 1, 1, 8'h00, 8'h3C, 5'b00000, 1, 1, 8'h8A); // halted, dbin ignored
    add(1, 0, 1, 0, 1, 8'hA2, 8'h00, 5'b00000, 1, 1, 8'h8A); // sync leaves halt
    add(1, 0, 0, 1, 1, 8'h00, 8'h99, 5'b10000, 0, 1, 8'hA2);
    add(1, 0, 0, 0, 1, 8'h00, 8'h00, 5'b00000, 0, 1, 8'hA2);
    add(1, 0, 1, 0, 1, 8'h23, 8'h00, 5'b00000, 0, 1, 8'hA2); // interrupt acknowledge
    add(1, 0, 0, 1, 1, 8'h00, 8'hC3, 5'b00001, 0, 1, 8'h23);
    add(1, 0, 0, 0, 1, 8'h00, 8'h00, 5'b00000, 0, 1, 8'h23);
    add(1, 0, 1, 0, 1, 8'hA2, 8'h00, 5'b00000, 0, 1, 8'h23);
    add(1, 0, 0, 1, 1, 8'h00, 8'h11, 5'b10000, 0, 1, 8'hA2);
    add(1, 1, 0, 1, 1, 8'h00, 8'h11, 5'b10000, 0, 1, 8'hA2); // reset mid-cycle
    add(1, 0, 0, 1, 1, 8'h00, 8'h11, 5'b00000, 0, 1, 8'h00); // strobes gone after reset edge

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].r, tbl[k].sy, tbl[k].d, tbl[k].w, tbl[k].b, tbl[k].s);
      if (tbl[k].chk) begin
        chk($sformatf("tbl%0d", k),
            32'({memr_o[0], memw_o[0], ior_o[0], iow_o[0], inta_o[0], halt_o[0], ready_o[0], st_o[0]}),
            32'({tbl[k].stb, tbl[k].h, tbl[k].rdy, tbl[k].st}));
        data_chk(0, tbl[k].stb, $sformatf("tbl%0d", k));
      end
      check_model();
      tick();
    end

    // Two wait states on an I/O read: READY low for exactly two cycles, ior gated meanwhile
    drive(0, 1, 0, 1, 8'h42, 8'h00); check_model(); tick();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 1, 1, 8'h00, 8'h5E); check_model();
      chk($sformatf("ws2_ready_c%0d", c), 32'(ready_o[1]), (c < 2) ? 32'd0 : 32'd1);
      chk($sformatf("ws2_ior_c%0d", c), 32'(ior_o[1]), (c < 2) ? 32'd0 : 32'd1);
      chk($sformatf("ws0_ior_c%0d", c), 32'(ior_o[0]), 32'd1);
      tick();
    end
    chk("ws2_bus_rd", 32'(bus2), 32'h5E);
    drive(0, 0, 0, 1, 8'h00, 8'h00); check_model();
    chk("ws2_ior_drop", 32'(ior_o[1]), 32'd0);
    tick();

    // Halt status with wait states pending: halt wins and READY comes back high
    drive(0, 1, 0, 1, 8'h8A, 8'h00); check_model(); tick();
    drive(0, 0, 0, 1, 8'h00, 8'h00); check_model();
    chk("ws2_halt_wait", 32'({halt_o[1], ready_o[1]}), 32'b00);
    tick();
    drive(0, 0, 1, 1, 8'h00, 8'h66); check_model();
    chk("ws2_halt_on", 32'({halt_o[1], ready_o[1], memr_o[1]}), 32'b110);
    tick();

    // Randomized traffic checked against the model
    for (int k = 0; k < 3000; k++) begin
      bit r, sy, d, w;
      int m;
      r  = ($urandom_range(0, 63) == 0);
      sy = ($urandom_range(0, 5) == 0);
      m  = $urandom_range(0, 2);
      d  = !sy && (m == 1);
      w  = !(!sy && (m == 2));
      drive(r, sy, d, w, sy ? pick_status() : 8'($urandom_range(1, 255)),
            8'($urandom_range(1, 255)));
      check_model();
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
